// File: rtl/rgb2ycbcr_pipe_pkg.sv
// ============================================================================
// rgb2ycbcr_pipe_pkg : mode encodings, Q8 coefficient table, rounding constants
// Rev 1.0
// ============================================================================
`default_nettype none

package rgb2ycbcr_pipe_pkg;

    localparam int COEF_W = 9;
    localparam int FRAC_W = 8;
    localparam int ROUND  = 128;

    // {std, range}: std 0 = BT.601, 1 = BT.709; range 0 = full, 1 = limited
    typedef enum logic [1:0] {
        MODE_601_FULL = 2'b00,
        MODE_601_LIM  = 2'b01,
        MODE_709_FULL = 2'b10,
        MODE_709_LIM  = 2'b11
    } mode_e;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef struct packed {
        coef_t y_r;  coef_t y_g;  coef_t y_b;
        coef_t cb_r; coef_t cb_g; coef_t cb_b;
        coef_t cr_r; coef_t cr_g; coef_t cr_b;
    } coef_set_t;

    function automatic coef_set_t coef_lookup(mode_e mode);
        coef_set_t set;
        case (mode)
            MODE_601_FULL: set = '{9'sd77,  9'sd150, 9'sd29, -9'sd43, -9'sd85, 9'sd128, 9'sd128, -9'sd107, -9'sd21};
            MODE_709_FULL: set = '{9'sd54,  9'sd183, 9'sd19, -9'sd29, -9'sd99, 9'sd128, 9'sd128, -9'sd116, -9'sd12};
            MODE_601_LIM:  set = '{9'sd66,  9'sd129, 9'sd25, -9'sd38, -9'sd74, 9'sd112, 9'sd112, -9'sd94,  -9'sd18};
            MODE_709_LIM:  set = '{9'sd47,  9'sd157, 9'sd16, -9'sd25, -9'sd87, 9'sd112, 9'sd112, -9'sd102, -9'sd10};
            default:       set = '0;
        endcase
        return set;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ycc_channel.sv
// ============================================================================
// ycc_channel : 3-term Q8 MAC with offset, rounding, shift and clamp (3 stages)
// Rev 1.0
// ============================================================================
`default_nettype none

module ycc_channel
    import rgb2ycbcr_pipe_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] comp_r,
    input  logic [DATA_W-1:0] comp_g,
    input  logic [DATA_W-1:0] comp_b,
    input  logic [8:0]        coef_r,
    input  logic [8:0]        coef_g,
    input  logic [8:0]        coef_b,
    input  logic [DATA_W+10:0] offset,
    output logic [DATA_W-1:0] result
);

    localparam int ACC_W  = DATA_W + 11;
    localparam int PROD_W = DATA_W + COEF_W + 1;

    localparam logic signed [ACC_W-1:0] c_round = ACC_W'(ROUND);

    logic signed [PROD_W-1:0] r_prod_r, r_prod_g, r_prod_b;
    logic signed [ACC_W-1:0]  r_off;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  r_sum;
    logic signed [ACC_W-1:0]  w_shift;
    logic [DATA_W-1:0]        w_clamped;
    logic [DATA_W-1:0]        r_result;

    // Components are unsigned; extend before the signed multiply
    function automatic logic signed [PROD_W-1:0] mul_term(logic [8:0] coef, logic [DATA_W-1:0] comp);
        logic signed [PROD_W-1:0] coef_ext;
        logic signed [PROD_W-1:0] comp_ext;
        coef_ext = PROD_W'($signed(coef));
        comp_ext = PROD_W'(comp);
        return coef_ext * comp_ext;
    endfunction

    always_comb begin
        w_sum   = ACC_W'(r_prod_r) + ACC_W'(r_prod_g) + ACC_W'(r_prod_b) + r_off + c_round;
        w_shift = r_sum >>> FRAC_W;
        if (w_shift[ACC_W-1]) begin
            w_clamped = '0;
        end else if (|w_shift[ACC_W-2:DATA_W]) begin
            w_clamped = '1;
        end else begin
            w_clamped = w_shift[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_r <= '0;
            r_prod_g <= '0;
            r_prod_b <= '0;
            r_off    <= '0;
            r_sum    <= '0;
            r_result <= '0;
        end else begin
            r_prod_r <= mul_term(coef_r, comp_r);
            r_prod_g <= mul_term(coef_g, comp_g);
            r_prod_b <= mul_term(coef_b, comp_b);
            r_off    <= offset;
            r_sum    <= w_sum;
            r_result <= w_clamped;
        end
    end

    assign result = r_result;

endmodule

`default_nettype wire

// File: rtl/rgb2ycbcr_pipe.sv
// ============================================================================
// rgb2ycbcr_pipe : RGB -> YCbCr444, BT.601/709, full/limited, frame-latched mode
// Rev 1.0
// ============================================================================
`default_nettype none

module rgb2ycbcr_pipe
    import rgb2ycbcr_pipe_pkg::*;
#(
    parameter int   DATA_W      = 8,
    parameter logic VSYNC_VALID = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_red,
    input  logic [DATA_W-1:0] per_img_green,
    input  logic [DATA_W-1:0] per_img_blue,
    input  logic              cfg_std,
    input  logic              cfg_range,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img_Y,
    output logic [DATA_W-1:0] post_img_Cb,
    output logic [DATA_W-1:0] post_img_Cr
);

    localparam int ACC_W = DATA_W + 11;

    // Offsets pre-scaled by 2^FRAC_W so they add straight into the accumulator
    localparam logic [ACC_W-1:0] c_y_off_lim = ACC_W'(32'd16 << DATA_W);
    localparam logic [ACC_W-1:0] c_c_off     = ACC_W'(32'd1 << (DATA_W + FRAC_W - 1));

    logic              r_vsync_d;
    logic              w_frame_start;
    logic              r_armed;
    logic              w_href_in;
    logic              w_clken_in;
    mode_e             r_mode;
    coef_set_t         w_coef;
    logic [ACC_W-1:0]  w_y_off;
    logic [2:0]        r_vsync_dl;
    logic [2:0]        r_href_dl;
    logic [2:0]        r_clken_dl;
    logic [DATA_W-1:0] w_y, w_cb, w_cr;

    assign w_frame_start = (per_frame_vsync == VSYNC_VALID) && (r_vsync_d != VSYNC_VALID);

    // After reset nothing is passed on until a genuine frame start is seen
    assign w_href_in  = per_frame_href  & (r_armed | w_frame_start);
    assign w_clken_in = per_frame_clken & (r_armed | w_frame_start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d  <= VSYNC_VALID;
            r_mode     <= MODE_601_FULL;
            r_armed    <= 1'b0;
            r_vsync_dl <= '0;
            r_href_dl  <= '0;
            r_clken_dl <= '0;
        end else begin
            r_vsync_d <= per_frame_vsync;
            if (w_frame_start) begin
                r_mode  <= mode_e'({cfg_std, cfg_range});
                r_armed <= 1'b1;
            end
            r_vsync_dl <= {r_vsync_dl[1:0], per_frame_vsync};
            r_href_dl  <= {r_href_dl[1:0],  w_href_in};
            r_clken_dl <= {r_clken_dl[1:0], w_clken_in};
        end
    end

    assign w_coef  = coef_lookup(r_mode);
    assign w_y_off = (r_mode == MODE_601_LIM || r_mode == MODE_709_LIM) ? c_y_off_lim : '0;

    ycc_channel #(.DATA_W(DATA_W)) u_ch_y (
        .clk    (clk),
        .rst_n  (rst_n),
        .comp_r (per_img_red),
        .comp_g (per_img_green),
        .comp_b (per_img_blue),
        .coef_r (w_coef.y_r),
        .coef_g (w_coef.y_g),
        .coef_b (w_coef.y_b),
        .offset (w_y_off),
        .result (w_y)
    );

    ycc_channel #(.DATA_W(DATA_W)) u_ch_cb (
        .clk    (clk),
        .rst_n  (rst_n),
        .comp_r (per_img_red),
        .comp_g (per_img_green),
        .comp_b (per_img_blue),
        .coef_r (w_coef.cb_r),
        .coef_g (w_coef.cb_g),
        .coef_b (w_coef.cb_b),
        .offset (c_c_off),
        .result (w_cb)
    );

    ycc_channel #(.DATA_W(DATA_W)) u_ch_cr (
        .clk    (clk),
        .rst_n  (rst_n),
        .comp_r (per_img_red),
        .comp_g (per_img_green),
        .comp_b (per_img_blue),
        .coef_r (w_coef.cr_r),
        .coef_g (w_coef.cr_g),
        .coef_b (w_coef.cr_b),
        .offset (c_c_off),
        .result (w_cr)
    );

    assign post_frame_vsync = r_vsync_dl[2];
    assign post_frame_href  = r_href_dl[2];
    assign post_frame_clken = r_clken_dl[2];
    assign post_img_Y       = r_href_dl[2] ? w_y  : '0;
    assign post_img_Cb      = r_href_dl[2] ? w_cb : '0;
    assign post_img_Cr      = r_href_dl[2] ? w_cr : '0;

endmodule

`default_nettype wire

// File: tb/tb_rgb2ycbcr_pipe.sv
// ============================================================================
// tb_rgb2ycbcr_pipe : scoreboard bench for rgb2ycbcr_pipe at DATA_W 8 and 10
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rgb2ycbcr_pipe;

    typedef struct {
        int y;
        int cb;
        int cr;
        bit ck;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, vsync, href, clken, cfg_std, cfg_range;
    logic [7:0] red, grn, blu;
    logic [9:0] red10, grn10, blu10;
    logic       pv8, ph8, pc8, pv10, ph10, pc10;
    logic [7:0] y8, cb8, cr8;
    logic [9:0] y10, cb10, cr10;

    assign red10 = {red, red[7:6]};
    assign grn10 = {grn, grn[7:6]};
    assign blu10 = {blu, blu[7:6]};

    rgb2ycbcr_pipe #(.DATA_W(8), .VSYNC_VALID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img_red(red), .per_img_green(grn), .per_img_blue(blu),
        .cfg_std(cfg_std), .cfg_range(cfg_range),
        .post_frame_vsync(pv8), .post_frame_href(ph8), .post_frame_clken(pc8),
        .post_img_Y(y8), .post_img_Cb(cb8), .post_img_Cr(cr8)
    );

    rgb2ycbcr_pipe #(.DATA_W(10), .VSYNC_VALID(1'b1)) dut10 (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img_red(red10), .per_img_green(grn10), .per_img_blue(blu10),
        .cfg_std(cfg_std), .cfg_range(cfg_range),
        .post_frame_vsync(pv10), .post_frame_href(ph10), .post_frame_clken(pc10),
        .post_img_Y(y10), .post_img_Cb(cb10), .post_img_Cr(cr10)
    );

    always #5 clk = ~clk;

    // Rows: 601 full, 601 lim, 709 full, 709 lim; columns Y(R,G,B) Cb(R,G,B) Cr(R,G,B)
    int coef_tbl [0:3][0:8] = '{
        '{77, 150, 29, -43, -85, 128, 128, -107, -21},
        '{66, 129, 25, -38, -74, 112, 112,  -94, -18},
        '{54, 183, 19, -29, -99, 128, 128, -116, -12},
        '{47, 157, 16, -25, -87, 112, 112, -102, -10}
    };

    exp_t q8[$];
    exp_t q10[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tb_mode = 0;
    bit   tb_armed = 1'b0;
    bit   tb_prev_v = 1'b1;
    bit   chk_sync = 1'b0;
    bit   chk_range = 1'b0;
    logic [2:0] hv = '0, hh = '0, hc = '0;

    function automatic int model(int mode, int w, int ch, int r, int g, int b);
        int off, acc, q;
        off = (ch == 0) ? (((mode % 2) == 1) ? (16 << (w - 8)) : 0) : (1 << (w - 1));
        acc = coef_tbl[mode][ch*3] * r + coef_tbl[mode][ch*3+1] * g + coef_tbl[mode][ch*3+2] * b
              + off * 256 + 128;
        q = acc >>> 8;
        if (q < 0) q = 0;
        if (q > (1 << w) - 1) q = (1 << w) - 1;
        return q;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit v, bit h, bit c, logic [7:0] r, logic [7:0] g, logic [7:0] b);
        @(negedge clk);
        vsync = v; href = h; clken = c; red = r; grn = g; blu = b;
        if (v && !tb_prev_v) begin
            tb_mode  = {30'd0, cfg_std, cfg_range};
            tb_armed = 1'b1;
        end
        tb_prev_v = v;
    endtask

    // Negative expected value means "take it from the model"
    task automatic push(int r, int g, int b, bit ck, int ey, int ecb, int ecr,
                        int ey10, int ecb10, int ecr10);
        exp_t e;
        int r10, g10, b10;
        if (!tb_armed) return;
        e.ck = ck;
        e.y  = (ey  < 0) ? model(tb_mode, 8, 0, r, g, b) : ey;
        e.cb = (ecb < 0) ? model(tb_mode, 8, 1, r, g, b) : ecb;
        e.cr = (ecr < 0) ? model(tb_mode, 8, 2, r, g, b) : ecr;
        q8.push_back(e);
        r10 = (r << 2) | (r >> 6);
        g10 = (g << 2) | (g >> 6);
        b10 = (b << 2) | (b >> 6);
        e.y  = (ey10  < 0) ? model(tb_mode, 10, 0, r10, g10, b10) : ey10;
        e.cb = (ecb10 < 0) ? model(tb_mode, 10, 1, r10, g10, b10) : ecb10;
        e.cr = (ecr10 < 0) ? model(tb_mode, 10, 2, r10, g10, b10) : ecr10;
        q10.push_back(e);
    endtask

    task automatic px(logic [7:0] r, logic [7:0] g, logic [7:0] b, bit ck);
        drive(1'b0, 1'b1, ck, r, g, b);
        push(int'(r), int'(g), int'(b), ck, -1, -1, -1, -1, -1, -1);
    endtask

    task automatic pxe(logic [7:0] r, logic [7:0] g, logic [7:0] b, int ey, int ecb, int ecr,
                       int ey10, int ecb10, int ecr10);
        drive(1'b0, 1'b1, 1'b1, r, g, b);
        push(int'(r), int'(g), int'(b), 1'b1, ey, ecb, ecr, ey10, ecb10, ecr10);
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic frame_start();
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        idle(2);
    endtask

    // Monitor: history of DUT inputs, then compare outputs just after the edge
    initial begin
        forever begin
            @(posedge clk);
            hv = {hv[1:0], vsync};
            hh = {hh[1:0], href};
            hc = {hc[1:0], clken};
            #1;
            if (rst_n) begin
                if (chk_sync) begin
                    chk("sync_vsync", int'(pv8), int'(hv[2]));
                    chk("sync_href",  int'(ph8), int'(hh[2]));
                    chk("sync_clken", int'(pc8), int'(hc[2]));
                    chk("sync_href10", int'(ph10), int'(hh[2]));
                end
                if (ph8) begin
                    if (q8.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL sb8_extra: got output Y=%0d, expected none at %0t", y8, $time);
                    end else begin
                        m_e = q8.pop_front();
                        chk("y8", int'(y8), m_e.y);
                        chk("cb8", int'(cb8), m_e.cb);
                        chk("cr8", int'(cr8), m_e.cr);
                        chk("clken8", int'(pc8), int'(m_e.ck));
                    end
                    if (chk_range) begin
                        n_tests++;
                        if (y8 < 8'd16 || y8 > 8'd240 || cb8 < 8'd16 || cb8 > 8'd240 ||
                            cr8 < 8'd16 || cr8 > 8'd240) begin
                            n_fail++;
                            $display("FAIL lim_range: got %0d/%0d/%0d, required within 16..240",
                                     y8, cb8, cr8);
                        end
                    end
                end else begin
                    chk("gate8", int'({y8, cb8, cr8}), 0);
                end
                if (ph10) begin
                    if (q10.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL sb10_extra: got output Y=%0d, expected none at %0t", y10, $time);
                    end else begin
                        m_e = q10.pop_front();
                        chk("y10", int'(y10), m_e.y);
                        chk("cb10", int'(cb10), m_e.cb);
                        chk("cr10", int'(cr10), m_e.cr);
                        chk("clken10", int'(pc10), int'(m_e.ck));
                    end
                end else begin
                    chk("gate10", int'({y10, cb10, cr10}), 0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0;
        red = '0; grn = '0; blu = '0; cfg_std = 1'b0; cfg_range = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vsync", int'(pv8), 0);
        chk("rst_href", int'(ph8), 0);
        chk("rst_clken", int'(pc8), 0);
        chk("rst_ycc", int'({y8, cb8, cr8}), 0);
        rst_n = 1'b1;
        idle(2);

        // 601 full: white, black, primaries
        cfg_std = 1'b0; cfg_range = 1'b0;
        frame_start();
        pxe(8'd255, 8'd255, 8'd255, 255, 128, 128, 1023, 512, 512);
        pxe(8'd0,   8'd0,   8'd0,   0,   128, 128, 0,    512, 512);
        pxe(8'd255, 8'd0,   8'd0,   77,  85,  255, -1,   -1,  1023);
        pxe(8'd0,   8'd255, 8'd0,   149, 43,  21,  -1,   -1,  -1);
        idle(4);

        // 601 limited: white, black, blue, random sweep inside 16..240
        cfg_range = 1'b1;
        frame_start();
        chk_range = 1'b1;
        pxe(8'd255, 8'd255, 8'd255, 235, 128, 128, -1, -1, -1);
        pxe(8'd0,   8'd0,   8'd0,   16,  128, 128, -1, -1, -1);
        pxe(8'd0,   8'd0,   8'd255, 41,  240, 110, -1, -1, -1);
        for (int i = 0; i < 40; i++)
            px(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
        idle(4);
        chk_range = 1'b0;

        // Mid-frame switch to 709 only takes effect at the next frame
        cfg_std = 1'b0; cfg_range = 1'b0;
        frame_start();
        pxe(8'd255, 8'd0, 8'd0, 77, 85, 255, -1, -1, -1);
        cfg_std = 1'b1;
        pxe(8'd255, 8'd0, 8'd0, 77, 85, 255, -1, -1, -1);
        pxe(8'd0, 8'd255, 8'd0, 149, 43, 21, -1, -1, -1);
        idle(3);
        frame_start();
        pxe(8'd255, 8'd255, 8'd255, 255, 128, 128, 1023, 512, 512);
        pxe(8'd255, 8'd0,   8'd0,   54,  99,  255, -1,   -1,  -1);
        idle(4);

        // 16x4 camera frame, 709 limited, clken gaps and href low between lines
        cfg_std = 1'b1; cfg_range = 1'b1;
        chk_sync = 1'b1;
        frame_start();
        for (int yl = 0; yl < 4; yl++) begin
            for (int x = 0; x < 16; x++)
                px(8'(x * 16), 8'(yl * 64 + x), 8'(255 - x * 16), (x % 5) != 4);
            idle(4);
        end
        idle(2);
        chk_sync = 1'b0;

        // Reset mid-line for 2 clk; outputs clear at once, resume on the next frame
        cfg_std = 1'b0; cfg_range = 1'b0;
        frame_start();
        px(8'd10, 8'd200, 8'd30, 1'b1);
        px(8'd90, 8'd20,  8'd250, 1'b1);
        px(8'd160, 8'd160, 8'd5, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        q8.delete(); q10.delete();
        tb_armed = 1'b0; tb_prev_v = 1'b1;
        #1;
        chk("arst_href", int'(ph8), 0);
        chk("arst_clken", int'(pc8), 0);
        chk("arst_ycc8", int'({y8, cb8, cr8}), 0);
        chk("arst_ycc10", int'({y10, cb10, cr10}), 0);
        repeat (2) px(8'd50, 8'd60, 8'd70, 1'b1);
        rst_n = 1'b1;
        repeat (4) px(8'd200, 8'd100, 8'd50, 1'b1);
        idle(3);
        frame_start();
        pxe(8'd255, 8'd255, 8'd255, 255, 128, 128, 1023, 512, 512);
        pxe(8'd255, 8'd0,   8'd0,   77,  85,  255, -1,   -1,  -1);
        px(8'd33, 8'd144, 8'd222, 1'b0);
        idle(6);

        chk("q8_drained", q8.size(), 0);
        chk("q10_drained", q10.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
